sd_otf_converter: RTL
=====================

# sd_otf_converter

Drains the MSD-first signed-digit quotient stream produced by the online divider and converts it to conventional two's-complement binary using on-the-fly conversion (Q/QM register pair), one digit per cycle. It sits downstream of the fractional-residue datapath. It tags each converted line with the row address captured at the line's first digit, and hands the result to the write-back stage over a valid/ready handshake.

## Interface
- DIGITS, 64, fractional digits per line (matches UNROLLING of the residue path)
- ADDR_WIDTH, 7, width of the line address tag
- clk  in  1  clock, all state updates on rising edge
- asyn_reset  in  1  reset, synchronous, active-high (name kept for codebase consistency; sampled only on clk)
- in_valid  in  1  digit present
- in_ready  out  1  converter accepts a digit this cycle
- new_line  in  1  qualifies the accepted digit as the first of a line
- in_plus  in  1  digit positive bit
- in_minus  in  1  digit negative bit; digit = in_plus − in_minus
- addr  in  ADDR_WIDTH  line address, sampled with first digit
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- out_data  out  DIGITS+1  two's-complement result, 1 sign/integer bit + DIGITS fraction bits
- out_addr  out  ADDR_WIDTH  tag of the result
- restart_err  out  1  one-cycle pulse: line aborted by early new_line

## Operation
- FSM states: IDLE, CONV, DONE.
- Reset: state IDLE, Q=0, QM=all ones, count=0, in_ready=0 during reset cycle then 1, out_valid=0, out_data=0, out_addr=0, restart_err=0.
- Handshake: digit accepted when in_valid && in_ready. in_ready=1 in IDLE and CONV, 0 in DONE.
- IDLE: accepted digit without new_line is dropped. Accepted digit with new_line loads Q=0 and QM=all ones, applies the digit, latches addr, sets count=1, and moves to CONV.
- CONV: each accepted digit applies the update and increments count. Accepted digit with new_line discards the partial line, pulses restart_err, and restarts as in IDLE. When count reaches N_DIG after the accept, move to DONE.
- Digit update (left shift, insert LSB):
  - d=+1: Q←{Q,1}, QM←{Q,0}
  - d=0: Q←{Q,0}, QM←{QM,1}
  - d=−1: Q←{QM,1}, QM←{QM,0}
- in_plus=in_minus=1 is treated as d=0.
- Register widths: DIGITS+1 bits. The MSB shifted out is discarded; the value is bounded in (−1,1), so no overflow.
- DONE: out_valid=1, out_data=selected register, out_addr=latched addr. On out_ready, move to IDLE and clear out_valid.
- N_DIG=DIGITS (macro off) or DIGITS+1 (macro on).

## Timing
- out_valid rises the cycle after the final digit is accepted.
- Throughput: one line per N_DIG+1 cycles when out_ready is held high. There is no digit acceptance in the DONE cycle.
- out_data/out_addr are stable while out_valid && !out_ready.
- Reset mid-line or in DONE: result is discarded; all outputs take reset values on the next edge.
- Simultaneous out_ready in DONE with in_valid: the digit is not accepted that cycle (in_ready=0).

## Configuration
- SD_OTF_ROUND_EN defined: one guard digit is consumed (N_DIG=DIGITS+1). The guard digit does not shift Q/QM; it selects out_data = QM if the guard digit is −1, else Q (floor correction).
- Undefined: exactly DIGITS digits are consumed; out_data=Q.

## Structure
- Package sd_div_pkg:
  - state enum {IDLE, CONV, DONE}
  - digit encoding constants (SD_POS=2'b10, SD_ZERO=2'b00, SD_NEG=2'b01)
  - shared DIGITS/ADDR_WIDTH defaults
- Sub-module sd_otf_step: combinational single-digit Q/QM update, parameterised on width.
- Top holds the FSM, count, and tag/output registers.

## Test plan
All cases use DIGITS=8, macro off unless stated.
- Digits +1 (new_line), then seven 0, addr=5 → out_data=9'h080 (0.5), out_addr=5, out_valid 1 cycle after the 8th accept.
- Digits −1 (new_line), then seven 0 → out_data=9'h180 (−0.5).
- Digits +1, −1, then six 0 → out_data=9'h040 (0.25). Digits −1, +1, 0… → 9'h1C0 (−0.25).
- Hold out_ready=0 for 5 cycles in DONE while in_valid=1 → in_ready=0, out_data stable, no digits lost. Next line converts correctly after release.
- new_line asserted on the 4th digit → restart_err pulses once. The result reflects only the new line, and out_addr equals the new addr.
- Macro on: digits 0,0,0,0,0,0,0,+1, guard −1 → out_data=9'h000 (QM = 1−1 ulp). Guard +1 → 9'h001. Separately, asyn_reset in the middle of CONV → all outputs at reset values next cycle, and the partial line is never output.

Source files
------------

// File: rtl/sd_div_pkg.sv
// Shared types and constants for the signed-digit divider back end:
// converter FSM states, digit encodings and default line geometry.
package sd_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  // Digit encoding as {plus, minus}
  localparam logic [1:0] SD_POS  = 2'b10;
  localparam logic [1:0] SD_ZERO = 2'b00;
  localparam logic [1:0] SD_NEG  = 2'b01;

  localparam int DIGITS_DEF     = 64;
  localparam int ADDR_WIDTH_DEF = 7;

endpackage

// File: rtl/sd_otf_step.sv
// One on-the-fly conversion step: shifts one signed digit into the Q/QM
// register pair. Q holds the converted prefix, QM holds Q minus one ulp,
// so a negative digit never needs a borrow chain. The {1,1} code is
// treated as a zero digit.
module sd_otf_step
  import sd_div_pkg::*;
#(
  parameter int W = 65
) (
  input  logic [W-1:0] q,
  input  logic [W-1:0] qm,
  input  logic         plus,
  input  logic         minus,
  output logic [W-1:0] q_next,
  output logic [W-1:0] qm_next
);

  // Select the shifted-in source register and LSB for each digit value
  always_comb begin
    q_next  = {q[W-2:0], 1'b0};
    qm_next = {qm[W-2:0], 1'b1};
    case ({plus, minus})
      SD_POS: begin
        q_next  = {q[W-2:0], 1'b1};
        qm_next = {q[W-2:0], 1'b0};
      end
      SD_NEG: begin
        q_next  = {qm[W-2:0], 1'b1};
        qm_next = {qm[W-2:0], 1'b0};
      end
      SD_ZERO: begin
        q_next  = {q[W-2:0], 1'b0};
        qm_next = {qm[W-2:0], 1'b1};
      end
      default: begin
        q_next  = {q[W-2:0], 1'b0};
        qm_next = {qm[W-2:0], 1'b1};
      end
    endcase
  end

endmodule

// File: rtl/sd_otf_converter.sv
// Converts an MSD-first signed-digit quotient line into a two's-complement
// result (1 integer/sign bit + DIGITS fraction bits), tags it with the
// line address and presents it over a valid/ready handshake.
// Optional feature macro: SD_OTF_ROUND_EN -- consume one extra guard digit
// that picks QM (guard = -1) or Q as the floor-corrected result.
module sd_otf_converter
  import sd_div_pkg::*;
#(
  parameter int DIGITS     = DIGITS_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  asyn_reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  new_line,
  input  logic                  in_plus,
  input  logic                  in_minus,
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DIGITS:0]       out_data,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic                  restart_err
);

  localparam int W = DIGITS + 1;
`ifdef SD_OTF_ROUND_EN
  localparam int N_DIG = DIGITS + 1;
`else
  localparam int N_DIG = DIGITS;
`endif
  localparam int CW = $clog2(N_DIG + 1);

  state_t        state, state_next;
  logic [W-1:0]  q, qm, q_base, qm_base, q_step, qm_step, result;
  logic [CW-1:0] count, count_new;
  logic          accept, first, live, last, shift_en;

  assign accept    = in_valid && in_ready;
  // A new_line digit always (re)starts a line; other digits only count in CONV
  assign first     = accept && new_line;
  assign live      = first || (accept && (state == CONV));
  assign count_new = first ? CW'(1) : count + CW'(1);
  assign last      = live && (count_new == CW'(N_DIG));
  assign q_base    = first ? '0 : q;
  assign qm_base   = first ? '1 : qm;

  sd_otf_step #(.W(W)) u_step (
    .q       (q_base),
    .qm      (qm_base),
    .plus    (in_plus),
    .minus   (in_minus),
    .q_next  (q_step),
    .qm_next (qm_step)
  );

`ifdef SD_OTF_ROUND_EN
  // The guard digit only chooses between the already converted Q and QM
  assign shift_en = live && !last;
  assign result   = (in_minus && !in_plus) ? qm : q;
`else
  assign shift_en = live;
  assign result   = q_step;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (asyn_reset) state <= IDLE;
    else            state <= state_next;
  end

  // Next-state: run a line in CONV, hold the result in DONE until taken
  always_comb begin
    state_next = state;
    case (state)
      IDLE, CONV: if (live) state_next = last ? DONE : CONV;
      DONE:       if (out_ready) state_next = IDLE;
      default:    state_next = IDLE;
    endcase
  end

  // Handshake outputs decoded from state; input is blocked while reset is held
  always_comb begin
    in_ready  = !asyn_reset && (state != DONE);
    out_valid = (state == DONE);
  end

  // Conversion registers, digit count, tag and result capture
  always_ff @(posedge clk) begin
    if (asyn_reset) begin
      q           <= '0;
      qm          <= '1;
      count       <= '0;
      out_data    <= '0;
      out_addr    <= '0;
      restart_err <= 1'b0;
    end else begin
      restart_err <= first && (state == CONV);
      if (live)     count    <= count_new;
      if (shift_en) begin
        q  <= q_step;
        qm <= qm_step;
      end
      if (first)    out_addr <= addr;
      if (last)     out_data <= result;
    end
  end

endmodule
